// File: rtl/urv_regfile_mp.sv
// Multi-read-port integer register file: one RAM bank per read port, a single writeback port,
// hardware zeroing after reset, a hardwired-zero x0 read path, and W/X bypass that stays correct across stalls.
module urv_regfile_mp #(
   parameter int unsigned G_XLEN           = 32,
   parameter int unsigned G_NREGS          = 32,
   parameter int unsigned G_NREAD          = 2,
   parameter int unsigned G_CLEAR_ON_RESET = 1,
   localparam int unsigned AW              = $clog2(G_NREGS)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        d_stall_i,
   input  logic [G_NREAD*AW-1:0]       rf_rs_i,
   input  logic [G_NREAD*AW-1:0]       d_rs_i,
   output logic [G_NREAD*G_XLEN-1:0]   x_rs_value_o,
   input  logic [AW-1:0]               w_rd_i,
   input  logic [G_XLEN-1:0]           w_rd_value_i,
   input  logic                        w_rd_store_i,
   input  logic                        w_bypass_rd_write_i,
   input  logic [G_XLEN-1:0]           w_bypass_rd_value_i,
   output logic                        busy_o
);

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;

   logic [G_XLEN-1:0]   bank_mem [G_NREAD][G_NREGS];

   logic [G_XLEN-1:0]   q_q    [G_NREAD];
   logic [G_XLEN-1:0]   q_d    [G_NREAD];
   logic [AW-1:0]       hold_q [G_NREAD];
   logic [AW-1:0]       hold_d [G_NREAD];
   logic                bw_q   [G_NREAD];
   logic                bw_d   [G_NREAD];
   logic [G_XLEN-1:0]   bv_q   [G_NREAD];
   logic [G_XLEN-1:0]   bv_d   [G_NREAD];

   logic                rd_en;
   logic                wr_en;
   logic                wr_go;
   logic [AW-1:0]       wr_addr;
   logic [G_XLEN-1:0]   wr_data;

   assign busy_o = busy_q;
   assign rd_en  = !d_stall_i && !busy_q;
   assign wr_en  = w_rd_store_i && (w_rd_i != '0) && !busy_q;

   // The clear sweep borrows the write port; normal writebacks are dropped meanwhile
   assign wr_go   = busy_q || wr_en;
   assign wr_addr = busy_q ? cnt_q : w_rd_i;
   assign wr_data = busy_q ? '0 : w_rd_value_i;

   // Clear sequencer: one entry per cycle, exactly G_NREGS cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(G_NREGS - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      end
      busy_d = (state_d == ST_CLEAR);
   end

   // Read pipeline and W-bypass; a held operand keeps tracking writes to its register
   always_comb begin
      q_d    = q_q;
      hold_d = hold_q;
      bw_d   = bw_q;
      bv_d   = bv_q;
      for (int k = 0; k < int'(G_NREAD); k++) begin
         if (rd_en) begin
            q_d[k]    = bank_mem[k][rf_rs_i[k*AW +: AW]];
            hold_d[k] = rf_rs_i[k*AW +: AW];
            bw_d[k]   = wr_en && (rf_rs_i[k*AW +: AW] == w_rd_i);
            if (bw_d[k]) begin
               bv_d[k] = w_rd_value_i;
            end
         end else if (wr_en && (hold_q[k] == w_rd_i)) begin
            bw_d[k] = 1'b1;
            bv_d[k] = w_rd_value_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= (G_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         cnt_q   <= '0;
         busy_q  <= (G_CLEAR_ON_RESET != 0);
         for (int k = 0; k < int'(G_NREAD); k++) begin
            q_q[k]    <= '0;
            hold_q[k] <= '0;
            bw_q[k]   <= 1'b0;
            bv_q[k]   <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         q_q     <= q_d;
         hold_q  <= hold_d;
         bw_q    <= bw_d;
         bv_q    <= bv_d;
      end
   end

   // Register banks: identical contents, one per read port
   always_ff @(posedge clk_i) begin
      if (wr_go) begin
         for (int k = 0; k < int'(G_NREAD); k++) begin
            bank_mem[k][wr_addr] <= wr_data;
         end
      end
   end

   // Operand select: x0, then X-bypass, then W-bypass, then RAM data
   always_comb begin
      x_rs_value_o = '0;
      for (int k = 0; k < int'(G_NREAD); k++) begin
         if (hold_q[k] == '0) begin
            x_rs_value_o[k*G_XLEN +: G_XLEN] = '0;
         end else if (w_bypass_rd_write_i && (w_rd_i == d_rs_i[k*AW +: AW]) && (w_rd_i != '0)) begin
            x_rs_value_o[k*G_XLEN +: G_XLEN] = w_bypass_rd_value_i;
         end else if (bw_q[k]) begin
            x_rs_value_o[k*G_XLEN +: G_XLEN] = bv_q[k];
         end else begin
            x_rs_value_o[k*G_XLEN +: G_XLEN] = q_q[k];
         end
      end
   end

endmodule
